// File: rtl/exec_if.sv
// Request/result handshake bundle between a client and exec_unit.
interface exec_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [15:0]      imm16;
  logic             use_imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             err;
  logic             bus_en;

  modport master (
    output in_valid, opcode, A, B, imm16, use_imm, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, err, bus_en
  );

  modport slave (
    input  in_valid, opcode, A, B, imm16, use_imm, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, err, bus_en
  );
endinterface

// File: rtl/exec_unit.sv
// Single-issue execution unit: 1-cycle ALU ops, bit-serial shifts (one bit per
// cycle), result held in DONE until the consumer takes it.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic             err;
    logic             c;
    logic             v;
    logic [WIDTH-1:0] res;
  } alu_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nx;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] b_eff;
  logic [4:0]       amt;
  logic             is_shift;
  logic             go_shift;
  alu_t             alu_r;

  function automatic alu_t alu(input logic [3:0] op,
                               input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    alu_t           r;
    logic [WIDTH:0] sum, dif, rdif;
    sum  = {1'b0, a} + {1'b0, b};
    dif  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    rdif = {1'b0, b} + {1'b0, ~a} + (WIDTH+1)'(1);
    r    = '0;
    case (op)
      4'd0: begin
        r.res = sum[WIDTH-1:0];
        r.c   = sum[WIDTH];
        r.v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        r.res = dif[WIDTH-1:0];
        r.c   = dif[WIDTH];
        r.v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  r.res = a & b;
      4'd3:  r.res = a | b;
      4'd4:  r.res = a ^ b;
      4'd5:  r.res = ~(a | b);
      4'd6:  r.res = ~a;
      4'd7:  r.res = a;
      4'd8:  r.res = b;
      4'd9:  r.res = {b[15:0], 16'h0000};
      // Raw sign of the difference, deliberately without overflow correction
      4'd10: r.res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1]};
      4'd11: r.res = {{(WIDTH-1){1'b0}}, rdif[WIDTH-1]};
      4'd12, 4'd13, 4'd14: r.res = a;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
    case (op)
      4'd12:   return {v[WIDTH-2:0], 1'b0};
      4'd13:   return {1'b0, v[WIDTH-1:1]};
      default: return {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign b_eff    = bus.use_imm ? {{(WIDTH-16){bus.imm16[15]}}, bus.imm16} : bus.B;
  assign amt      = b_eff[4:0];
  assign is_shift = (bus.opcode == 4'd12) || (bus.opcode == 4'd13) || (bus.opcode == 4'd14);
  assign go_shift = is_shift && (amt != 5'd0);
  assign alu_r    = alu(bus.opcode, bus.A, b_eff);
  assign sh_nx    = shift_step(op_q, sh_q);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bus_en    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = go_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == 5'd1) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operands latched on accept, outputs loaded only when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      bus.result <= '0;
      bus.flag_z <= 1'b0;
      bus.flag_c <= 1'b0;
      bus.flag_v <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.opcode;
          sh_q  <= bus.A;
          cnt_q <= amt;
          if (!go_shift) begin
            bus.result <= alu_r.res;
            bus.flag_z <= (alu_r.res == '0);
            bus.flag_c <= alu_r.c;
            bus.flag_v <= alu_r.v;
            bus.err    <= alu_r.err;
          end
        end
        SHIFT: begin
          sh_q  <= sh_nx;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            bus.result <= sh_nx;
            bus.flag_z <= (sh_nx == '0);
            bus.flag_c <= 1'b0;
            bus.flag_v <= 1'b0;
            bus.err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed and randomized bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  exec_if #(.WIDTH(32)) bus ();

  exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z, c, v, err;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint ua, ub, s;
    logic [31:0] t;
    int     n;
    e = '{res: 32'h0, z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0, lat: 1};
    ua = longint'(a);
    ub = longint'(b);
    n  = int'(b[4:0]);
    case (op)
      4'd0: begin
        e.res = a + b;
        e.c   = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        s     = longint'($signed(a)) + longint'($signed(b));
        e.v   = (s != longint'($signed(e.res)));
      end
      4'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = longint'($signed(a)) - longint'($signed(b));
        e.v   = (s != longint'($signed(e.res)));
      end
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ~(a | b);
      4'd6:  e.res = ~a;
      4'd7:  e.res = a;
      4'd8:  e.res = b;
      4'd9:  e.res = b << 16;
      4'd10: begin t = a - b; e.res = 32'(t[31]); end
      4'd11: begin t = b - a; e.res = 32'(t[31]); end
      4'd12: begin e.res = a << n; e.lat = n + 1; end
      4'd13: begin e.res = a >> n; e.lat = n + 1; end
      4'd14: begin e.res = $signed(a) >>> n; e.lat = n + 1; end
      default: begin e.res = 32'h0; e.err = 1'b1; end
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic ui, input int hold);
    exp_t        e;
    logic [31:0] effb;
    int          lat;
    effb = ui ? {{16{imm[15]}}, imm} : b;
    e    = model(op, a, effb);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    bus.imm16 = imm; bus.use_imm = ui; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.opcode = 4'($urandom); bus.A = $urandom; bus.B = $urandom;
    bus.imm16 = 16'($urandom); bus.use_imm = 1'($urandom_range(0, 1));
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(e.lat));
    check("result", bus.result, e.res);
    check("flag_z", 32'(bus.flag_z), 32'(e.z));
    check("flag_c", 32'(bus.flag_c), 32'(e.c));
    check("flag_v", 32'(bus.flag_v), 32'(e.v));
    check("err", 32'(bus.err), 32'(e.err));
    check("bus_en", 32'(bus.bus_en), 32'd1);
    bus.in_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", bus.result, e.res);
      check("hold_valid", 32'({bus.out_valid, bus.bus_en, bus.in_ready}), 32'b110);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("handoff_state", 32'({bus.out_valid, bus.bus_en, bus.in_ready}), 32'b001);
  endtask

  initial begin
    int seen;
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = 4'h0; bus.A = 32'h0; bus.B = 32'h0;
    bus.imm16 = 16'h0; bus.use_imm = 1'b0; bus.out_ready = 1'b0;
    #3;
    check("reset_outputs",
          32'({bus.in_ready, bus.out_valid, bus.bus_en, bus.flag_z, bus.flag_c, bus.flag_v, bus.err}),
          32'b1000000);
    check("reset_result", bus.result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first request right after reset release, then the directed corner cases
    do_op(4'd0,  32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 0);
    do_op(4'd1,  32'h8000_0000, 32'h1, 16'h0, 1'b0, 0);
    do_op(4'd10, 32'd5, 32'd7, 16'h0, 1'b0, 0);
    do_op(4'd11, 32'd5, 32'd7, 16'h0, 1'b0, 0);
    do_op(4'd14, 32'h8000_0000, 32'h0, 16'd4, 1'b1, 0);
    do_op(4'd12, 32'h1234_5678, 32'hFFFF_FFE0, 16'h0, 1'b0, 0);
    do_op(4'd9,  32'h0, 32'h0, 16'hABCD, 1'b1, 0);
    do_op(4'd15, 32'h1111_1111, 32'h2222_2222, 16'h0, 1'b0, 0);
    do_op(4'd0,  32'h7FFF_FFFF, 32'h0, 16'h0001, 1'b1, 10);
    do_op(4'd13, 32'hDEAD_BEEF, 32'h0, 16'hFFFF, 1'b1, 2);

    // reset during SRL n=20, at SHIFT cycle 7
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 4'd13; bus.A = 32'hF0F0_1234;
    bus.B = 32'd20; bus.use_imm = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pre_reset_busy", 32'({bus.in_ready, bus.out_valid}), 32'b00);
    rst_n = 1'b0;
    #1;
    check("midshift_reset_ctl",
          32'({bus.in_ready, bus.out_valid, bus.bus_en, bus.flag_z, bus.flag_c, bus.flag_v, bus.err}),
          32'b1000000);
    check("midshift_reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("no_valid_after_reset", 32'(seen), 32'd0);
    bus.out_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 16'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port opcode  input  4  operation select, encoding per REQ-014.
REQ-007 SHALL have port A  input  32  operand A.
REQ-008 SHALL have ports B  input  32 and imm16  input  16, the register and immediate operands.
REQ-009 SHALL have port use_imm  input  1  when 1, effective B = sign-extended imm16 (sign_ext rule), else B.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have ports result  output  32, flag_z  output  1, flag_c  output  1, flag_v  output  1, err  output  1.
REQ-013 SHALL have port bus_en  output  1  equal to out_valid; drives the enable of a tri_buff_in placing result on the shared bus.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT A, 7 pass A, 8 pass B, 9 LUI ({B[15:0],16'h0}), 10 SLT, 11 SGT, 12 SLL, 13 SRL, 14 SRA, 15 reserved.
REQ-015 SLT/SGT SHALL return {31'b0, sign bit of 32-bit A-B (resp. B-A)}, no overflow correction, bit-identical to sltgt_32.
REQ-016 FSM SHALL have states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-017 Handshake: request accepted on a rising edge with in_valid=1 and in_ready=1; opcode, A, effective B latched then; inputs ignored otherwise.
REQ-018 Opcodes 0-11 and 15: IDLE -> DONE on the accepting edge; out_valid=1 exactly 1 cycle after acceptance.
REQ-019 Shifts: amount n = effective B[4:0]; accept loads A into the shift register; n=0 -> DONE directly; n>0 -> SHIFT, one bit per cycle, DONE after n SHIFT cycles (out_valid n+1 cycles after acceptance).
REQ-020 SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates bit 31 each step.
REQ-021 DONE SHALL hold out_valid=1 with result and flags stable until a rising edge with out_ready=1, then go to IDLE (out_valid=0, in_ready=1 next cycle); no new request accepted in the same cycle as the result handoff.
REQ-022 flag_z = (result == 0) for every opcode.
REQ-023 flag_c = carry-out of 33-bit A + B (ADD) or A + ~B + 1 (SUB); flag_v = signed overflow of ADD/SUB; both 0 for all other opcodes.
REQ-024 Opcode 15 SHALL give result 0, flag_z=1, err=1, normal 1-cycle latency; err=0 for all other opcodes.
REQ-025 In SHIFT, in_valid and out_ready SHALL have no effect.
REQ-026 Result, flags and err SHALL be registered outputs; no combinational path from inputs to any output.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force state IDLE, in_ready=1, out_valid=0, bus_en=0, result=0, flag_z=0, flag_c=0, flag_v=0, err=0, shift register and count cleared.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result is presented after reset release.
REQ-029 First request is accepted on the first rising edge after rst_n rises with in_valid=1.

Verification
REQ-030 ADD A=0xFFFFFFFF, B=1, out_ready=1 -> 1 cycle later result=0, flag_z=1, flag_c=1, flag_v=0; next cycle in_ready=1.
REQ-031 SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, flag_v=1, flag_c=1; SLT A=5, B=7 -> result=1; SGT same operands -> result=0.
REQ-032 SRA A=0x80000000, use_imm=1, imm16=4 -> out_valid exactly 5 cycles after acceptance, result=0xF8000000; SLL with n=0 -> result=A after 1 cycle.
REQ-033 LUI use_imm=1, imm16=0xABCD -> result=0xABCD0000; opcode 15 -> result=0, err=1, flag_z=1.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, bus_en, result held constant, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low during SRL n=20 at SHIFT cycle 7 -> all outputs zero immediately, in_ready=1; no out_valid after release.
